signed_div_seq: RTL and testbench
=================================

Name: signed_div_seq

Overview:
- Sequential signed 32-bit divider for the multdiv unit. It is the output-side counterpart of the operand negation stage.
- Operands are converted to magnitudes on entry. A 32-iteration unsigned shift-subtract core runs on the magnitudes. The block then restores two's-complement signs on the quotient and remainder.
- It sits beside the multiplier under the multdiv top and drives the shared result, ready and exception outputs.

Parameters:
- WIDTH, 32, operand and result width (only 32 is verified).
- ITER, WIDTH, number of shift-subtract iterations.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge.
- data_operandA  input  WIDTH  dividend, signed.
- data_operandB  input  WIDTH  divisor, signed.
- data_result  output  WIDTH  quotient, signed, registered.
- data_remainder  output  WIDTH  remainder, signed, registered.
- data_resultRDY  output  1  one-cycle pulse when results are valid.
- data_exception  output  1  valid only with data_resultRDY: divide-by-zero or overflow.

Behaviour:
- Reset (asynchronous, any state): go to IDLE; data_result, data_remainder, data_resultRDY, data_exception and all internal registers are 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, ctrl_DIV=1 at edge E0:
  - Latch |A| and |B|.
  - Latch sign_q = A[31]^B[31] and sign_r = A[31].
  - Clear the partial remainder; counter = 0.
  - If B==0, go to DONE (zero path). Otherwise go to RUN.
- RUN, one iteration per clock:
  - Shift {rem, quot} left by 1.
  - If shifted rem >= |B|, subtract |B| from rem and set quot LSB to 1.
  - Counter increments. After ITER iterations, go to FIX.
- FIX:
  - Quotient = sign_q ? -quot : quot.
  - Remainder = sign_r ? -rem : rem.
  - Both are registered into the outputs. Go to DONE.
- DONE: data_resultRDY=1 for exactly this one cycle, then return to IDLE. Outputs hold their values until the next start or reset.
- Latency:
  - Normal case: data_resultRDY is high in the cycle after edge E0+ITER+1, i.e. sampled high at edge E0+34.
  - Divide-by-zero: data_resultRDY is sampled high at edge E0+1.
- Divide-by-zero: data_result=0, data_remainder=0, data_exception=1.
- Overflow (A=0x80000000, B=0xFFFFFFFF):
  - Runs the full latency.
  - data_result=0x80000000 (wrapped), data_remainder=0, data_exception=1.
- Magnitude of 0x80000000 is 0x80000000 held as unsigned; no special case is needed in the core.
- data_exception is 0 whenever data_resultRDY is 0.
- ctrl_DIV in RUN or FIX aborts the current operation. New operands are sampled and RUN restarts from iteration 0; no ready pulse is issued for the aborted operation.
- ctrl_DIV in DONE: the DONE pulse still occurs, and the new operation starts on that same edge.
- Operand inputs are ignored except on the start edge.
- Zero dividend: quotient 0, remainder 0, no exception, full latency.

Decomposition:
- Shared package multdiv_pkg holds:
  - WIDTH.
  - State encodings DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE.
  - OVF_DIVIDEND = 0x80000000.
- Sign handling at entry and in FIX reuses the existing conditional two's-complement negation block. It is instantiated four times: |A|, |B|, quotient fix, remainder fix.
- One natural sub-module: div_mag_core.
  - Holds the unsigned rem/quot shift-subtract registers and the iteration counter.
  - Signals: start, done_iter, quot, rem.

Test Plan:
- 100 / 7, start pulse → data_resultRDY sampled high exactly 34 edges later; q=14, r=2, exc=0; RDY low on the next cycle.
- Sign matrix:
  - -100/7 → q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2).
  - 100/-7 → q=-14, r=2.
  - -100/-7 → q=14, r=-2.
  - All four cases: exc=0.
- 5 / 0 → RDY at edge E0+1; q=0, r=0, exc=1. Then 0 / 9 → q=0, r=0, exc=0 at full latency.
- 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, exc=1. Also 0x80000000 / 2 → q=0xC0000000, r=0, exc=0.
- Restart: start 1000/3, reassert ctrl_DIV with 9/3 at iteration 10 → a single RDY pulse, 34 edges after the second start, with q=3, r=0.
- Async reset asserted mid-RUN (between clock edges) → all outputs 0 immediately. After release, 9/3 completes normally with q=3, r=0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: datapath width, divider FSM
// state encoding and the single signed-overflow dividend.
package multdiv_pkg;
  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam logic [WIDTH-1:0] OVF_DIVIDEND = {1'b1, {(WIDTH-1){1'b0}}};
endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation, used for entry magnitudes and
// for restoring signs on the divider results.
module cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);
  assign result = neg ? (-value) : value;
endmodule

// File: rtl/div_mag_core.sv
// Unsigned restoring shift-subtract core operating on operand magnitudes.
// Holds rem/quot, the latched divisor and the iteration counter.
module div_mag_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_iter,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  localparam int unsigned CW = $clog2(ITER + 1);

  logic [WIDTH-1:0] divisor_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] diff;
  logic             take;

  // rem[WIDTH-1] is the bit shifted out; if set, the shifted value exceeds
  // any WIDTH-bit divisor and the modular difference is still exact.
  always_comb begin
    rem_sh = {rem[WIDTH-2:0], quot[WIDTH-1]};
    take   = rem[WIDTH-1] | (rem_sh >= divisor_r);
    diff   = rem_sh - divisor_r;
  end

  assign done_iter = step && (cnt == CW'(ITER - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quot      <= '0;
      rem       <= '0;
      divisor_r <= '0;
      cnt       <= '0;
    end else if (start) begin
      quot      <= dividend;
      rem       <= '0;
      divisor_r <= divisor;
      cnt       <= '0;
    end else if (step) begin
      rem  <= take ? diff : rem_sh;
      quot <= {quot[WIDTH-2:0], take};
      cnt  <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/signed_div_seq.sv
// Sequential signed divider: magnitude conversion, ITER-step unsigned core,
// then sign restoration on quotient and remainder.
module signed_div_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = multdiv_pkg::WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_resultRDY,
  output logic             data_exception
);
  div_state_t state, state_next;

  logic [WIDTH-1:0] mag_a, mag_b, core_quot, core_rem, q_fixed, r_fixed;
  logic             sign_q, sign_r, ovf, done_iter, step, b_zero;

  assign b_zero = (data_operandB == '0);
  // A start in any state (including RUN/FIX) reloads the core; this aborts
  // any operation in flight without a ready pulse.
  assign step   = (state == DIV_RUN) && !ctrl_DIV;

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .value(data_operandA), .neg(data_operandA[WIDTH-1]), .result(mag_a));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .value(data_operandB), .neg(data_operandB[WIDTH-1]), .result(mag_b));
  cond_negate #(.WIDTH(WIDTH)) u_neg_q (
    .value(core_quot), .neg(sign_q), .result(q_fixed));
  cond_negate #(.WIDTH(WIDTH)) u_neg_r (
    .value(core_rem), .neg(sign_r), .result(r_fixed));

  div_mag_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
    .clock    (clock),
    .reset    (reset),
    .start    (ctrl_DIV),
    .step     (step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done_iter(done_iter),
    .quot     (core_quot),
    .rem      (core_rem)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ctrl_DIV) begin
      state_next = b_zero ? DIV_DONE : DIV_RUN;
    end else begin
      unique case (state)
        DIV_IDLE: state_next = DIV_IDLE;
        DIV_RUN:  state_next = done_iter ? DIV_FIX : DIV_RUN;
        DIV_FIX:  state_next = DIV_DONE;
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      ovf    <= 1'b0;
    end else if (ctrl_DIV) begin
      sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      sign_r <= data_operandA[WIDTH-1];
      ovf    <= (data_operandA == OVF_DIVIDEND) && (data_operandB == '1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV && b_zero) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_resultRDY <= 1'b1;
      data_exception <= 1'b1;
    end else if (!ctrl_DIV && state == DIV_FIX) begin
      data_result    <= q_fixed;
      data_remainder <= r_fixed;
      data_resultRDY <= 1'b1;
      data_exception <= ovf;
    end else begin
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end
  end
endmodule

// File: tb/tb_signed_div_seq.sv
// Directed bench for signed_div_seq: latency, sign matrix, divide-by-zero,
// overflow, restart, back-to-back start and asynchronous reset.
module tb_signed_div_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result, data_remainder;
  logic        data_resultRDY, data_exception;

  int total = 0;
  int bad   = 0;

  signed_div_seq #(.WIDTH(32), .ITER(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception)
  );

  always #5 clock = ~clock;

  // Starts a division on the next rising edge (E0), scrambles the operand
  // inputs afterwards, and reports the negedge index at which RDY is seen
  // (k=1 is the negedge right after E0) or -1 on timeout.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] q, output logic [31:0] r, output logic exc);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_DIV = 1'b0; data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    q = data_result; r = data_remainder; exc = data_exception;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({data_result, data_remainder, data_resultRDY, data_exception} !== 66'h0) begin
      bad++;
      $display("FAIL reset_state: got q=%h r=%h rdy=%b exc=%b want all 0",
               data_result, data_remainder, data_resultRDY, data_exception);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] q, r; logic exc;
    do_div(32'd100, 32'd7, lat, q, r, exc);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL basic_latency: got %0d want 34", lat); end
    total++;
    if (q !== 32'd14 || r !== 32'd2 || exc !== 1'b0) begin
      bad++; $display("FAIL basic_100_7: got q=%h r=%h exc=%b want q=0000000e r=00000002 exc=0", q, r, exc);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || data_exception !== 1'b0) begin
      bad++; $display("FAIL basic_rdy_pulse: got rdy=%b exc=%b want 0 0", data_resultRDY, data_exception);
    end
  endtask

  task automatic test_sign_matrix();
    logic [31:0] ta[3], tb_[3], tq[3], tr[3];
    int lat; logic [31:0] q, r; logic exc;
    ta  = '{32'hFFFF_FF9C, 32'd100,        32'hFFFF_FF9C};
    tb_ = '{32'd7,         32'hFFFF_FFF9,  32'hFFFF_FFF9};
    tq  = '{32'hFFFF_FFF2, 32'hFFFF_FFF2,  32'd14};
    tr  = '{32'hFFFF_FFFE, 32'd2,          32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      do_div(ta[i], tb_[i], lat, q, r, exc);
      total++;
      if (lat !== 34 || q !== tq[i] || r !== tr[i] || exc !== 1'b0) begin
        bad++;
        $display("FAIL sign_%0d: got lat=%0d q=%h r=%h exc=%b want lat=34 q=%h r=%h exc=0",
                 i, lat, q, r, exc, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] q, r; logic exc;
    do_div(32'd5, 32'd0, lat, q, r, exc);
    total++;
    if (lat !== 1 || q !== 32'd0 || r !== 32'd0 || exc !== 1'b1) begin
      bad++; $display("FAIL div_by_zero: got lat=%0d q=%h r=%h exc=%b want lat=1 q=0 r=0 exc=1", lat, q, r, exc);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || data_exception !== 1'b0) begin
      bad++; $display("FAIL div_zero_pulse: got rdy=%b exc=%b want 0 0", data_resultRDY, data_exception);
    end
    do_div(32'd0, 32'd9, lat, q, r, exc);
    total++;
    if (lat !== 34 || q !== 32'd0 || r !== 32'd0 || exc !== 1'b0) begin
      bad++; $display("FAIL zero_dividend: got lat=%0d q=%h r=%h exc=%b want lat=34 q=0 r=0 exc=0", lat, q, r, exc);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] q, r; logic exc;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, exc);
    total++;
    if (lat !== 34 || q !== 32'h8000_0000 || r !== 32'd0 || exc !== 1'b1) begin
      bad++; $display("FAIL overflow: got lat=%0d q=%h r=%h exc=%b want lat=34 q=80000000 r=0 exc=1", lat, q, r, exc);
    end
    do_div(32'h8000_0000, 32'd2, lat, q, r, exc);
    total++;
    if (lat !== 34 || q !== 32'hC000_0000 || r !== 32'd0 || exc !== 1'b0) begin
      bad++; $display("FAIL min_div_2: got lat=%0d q=%h r=%h exc=%b want lat=34 q=c0000000 r=0 exc=0", lat, q, r, exc);
    end
  endtask

  task automatic test_restart();
    int pulses = 0;
    int first = -1;
    logic [31:0] q = '0, r = '0;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_resultRDY) pulses++;
      @(negedge clock);
    end
    ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) begin first = k; q = data_result; r = data_remainder; end
      end
      @(negedge clock);
    end
    total++;
    if (pulses !== 1 || first !== 34) begin
      bad++; $display("FAIL restart_pulse: got pulses=%0d first=%0d want pulses=1 first=34", pulses, first);
    end
    total++;
    if (q !== 32'd3 || r !== 32'd0) begin
      bad++; $display("FAIL restart_value: got q=%h r=%h want q=3 r=0", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (k == 0) begin
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(negedge clock);
        ctrl_DIV = 1'b0;
      end
      if (data_resultRDY) lat = k;
      else @(negedge clock);
    end
    total++;
    if (lat < 0 || data_result !== 32'd14) begin
      bad++; $display("FAIL b2b_first: got lat=%0d q=%h want rdy with q=0000000e", lat, data_result);
    end
    // Start the next operation while RDY of the previous one is showing.
    ctrl_DIV = 1'b1; data_operandA = 32'hFFFF_FFF7; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (data_resultRDY) begin lat = k; break; end
      @(negedge clock);
    end
    total++;
    if (lat !== 34 || data_result !== 32'hFFFF_FFFD || data_remainder !== 32'd0) begin
      bad++; $display("FAIL b2b_second: got lat=%0d q=%h r=%h want lat=34 q=fffffffd r=0",
                      lat, data_result, data_remainder);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] q, r; logic exc;
    do_div(32'd100, 32'd7, lat, q, r, exc);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({data_result, data_remainder, data_resultRDY, data_exception} !== 66'h0) begin
      bad++; $display("FAIL async_reset: got q=%h r=%h rdy=%b exc=%b want all 0",
                      data_result, data_remainder, data_resultRDY, data_exception);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_div(32'd9, 32'd3, lat, q, r, exc);
    total++;
    if (lat !== 34 || q !== 32'd3 || r !== 32'd0 || exc !== 1'b0) begin
      bad++; $display("FAIL after_reset: got lat=%0d q=%h r=%h exc=%b want lat=34 q=3 r=0 exc=0", lat, q, r, exc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_matrix();
    test_div_zero();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
